// File: rtl/jtkunio_pkg.sv
// Shared types for the kunio SDRAM arbiter: access owner encoding, FSM states
// and small one-hot helpers.
package jtkunio_pkg;

  typedef enum logic [2:0] {
    OWN_B0   = 3'd0,
    OWN_B1   = 3'd1,
    OWN_B2   = 3'd2,
    OWN_B3   = 3'd3,
    OWN_PROG = 3'd4
  } own_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } st_e;

  // Owner to per-bank strobe mask; the download path has no bank bit.
  function automatic logic [3:0] own_onehot(input own_e own);
    logic [2:0] v;
    v = own;
    return (v == 3'd4) ? 4'b0000 : (4'b0001 << v[1:0]);
  endfunction

  // One-hot (at most one bit set) to bank index.
  function automatic logic [1:0] oh2idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/jtkunio_rr4.sv
// 4-way round-robin picker: first requester at or after i_ptr (wrapping) wins.
module jtkunio_rr4 (
  input  logic [3:0] i_req,
  input  logic [1:0] i_ptr,
  output logic [3:0] o_grant,
  output logic       o_valid
);

  logic [1:0] w_idx;
  logic       w_found;

  // Scan the four positions starting at the pointer, keep the first hit.
  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = 0; i < 4; i++) begin
      w_idx = i_ptr + 2'(i);
      if (!w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

  assign o_valid = |i_req;

endmodule

// File: rtl/jtkunio_sdram_arb.sv
// SDRAM command port arbiter for the four ROM bank requesters and the
// download path. One access in flight; strobes are routed back to the owner.
module jtkunio_sdram_arb #(
  parameter int AW         = 22,
  parameter int PRIO0      = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    ba_rd,
  input  logic [AW-1:0] ba0_addr,
  input  logic [AW-1:0] ba1_addr,
  input  logic [AW-1:0] ba2_addr,
  input  logic [AW-1:0] ba3_addr,
  output logic [3:0]    ba_ack,
  output logic [3:0]    ba_dst,
  output logic [3:0]    ba_dok,
  output logic [3:0]    ba_rdy,
  input  logic          downloading,
  input  logic          prog_we,
  input  logic          prog_rd,
  input  logic [AW-1:0] prog_addr,
  input  logic [1:0]    prog_ba,
  input  logic [15:0]   prog_data,
  input  logic [1:0]    prog_mask,
  output logic          prog_ack,
  output logic          prog_rdy,
  output logic          sdram_req,
  output logic          sdram_we,
  output logic [1:0]    sdram_ba,
  output logic [AW-1:0] sdram_addr,
  output logic [15:0]   sdram_din,
  output logic [1:0]    sdram_mask,
  input  logic          sdram_ack,
  input  logic          sdram_dst,
  input  logic          sdram_dok,
  input  logic          sdram_rdy
);
  import jtkunio_pkg::*;

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  st_e           r_state, w_state_nx;
  own_e          r_owner, w_own_nx;
  logic          r_we;
  logic [1:0]    r_ba;
  logic [AW-1:0] r_addr;
  logic [15:0]   r_din;
  logic [1:0]    r_mask;
  logic [1:0]    r_rr_ptr, w_rr_nx;
  logic [SW-1:0] r_starve, w_starve_nx;

  logic          w_load;
  logic          w_ld_we;
  logic [1:0]    w_ld_ba;
  logic [AW-1:0] w_ld_addr;
  logic [15:0]   w_ld_din;
  logic [1:0]    w_ld_mask;

  logic [3:0]    w_rr_grant;
  logic          w_rr_valid;
  logic          w_prio_win;
  logic [1:0]    w_bidx;
  logic [AW-1:0] w_bank_addr;
  logic [3:0]    w_own_oh;

  jtkunio_rr4 u_rr (
    .i_req   (ba_rd),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_rr_grant),
    .o_valid (w_rr_valid)
  );

  // Bank 0 jumps the queue until it has won STARVE_MAX times in a row.
  assign w_prio_win = (PRIO0 != 0) && ba_rd[0] && (r_starve < SW'(STARVE_MAX));
  assign w_bidx     = w_prio_win ? 2'd0 : oh2idx(w_rr_grant);
  assign w_own_oh   = own_onehot(r_owner);

  // Address of the bank about to be granted.
  always_comb begin
    case (w_bidx)
      2'd0:    w_bank_addr = ba0_addr;
      2'd1:    w_bank_addr = ba1_addr;
      2'd2:    w_bank_addr = ba2_addr;
      default: w_bank_addr = ba3_addr;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nx;
  end

  // Arbitration, next state and owner-routed strobes.
  always_comb begin
    w_state_nx  = r_state;
    w_own_nx    = r_owner;
    w_rr_nx     = r_rr_ptr;
    w_starve_nx = r_starve;
    w_load      = 1'b0;
    w_ld_we     = 1'b0;
    w_ld_ba     = '0;
    w_ld_addr   = '0;
    w_ld_din    = '0;
    w_ld_mask   = '0;
    ba_ack      = '0;
    ba_dst      = '0;
    ba_dok      = '0;
    ba_rdy      = '0;
    prog_ack    = 1'b0;
    prog_rdy    = 1'b0;
    sdram_req   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (downloading) begin
          // Banks stay pending while the ROM is being loaded.
          if (prog_we | prog_rd) begin
            w_load     = 1'b1;
            w_own_nx   = OWN_PROG;
            w_ld_we    = prog_we;
            w_ld_ba    = prog_ba;
            w_ld_addr  = prog_addr;
            w_ld_din   = prog_data;
            w_ld_mask  = prog_mask;
            w_state_nx = ST_REQ;
            if (!ba_rd[0]) w_starve_nx = '0;
          end
        end else if (w_rr_valid) begin
          w_load      = 1'b1;
          w_own_nx    = own_e'({1'b0, w_bidx});
          w_ld_ba     = w_bidx;
          w_ld_addr   = w_bank_addr;
          w_rr_nx     = w_bidx + 2'd1;
          w_starve_nx = w_prio_win ? r_starve + SW'(1) : '0;
          w_state_nx  = ST_REQ;
        end
      end
      ST_REQ: begin
        sdram_req = 1'b1;
        if (sdram_ack) begin
          ba_ack   = w_own_oh;
          prog_ack = (r_owner == OWN_PROG);
          if (sdram_rdy) begin
            ba_rdy     = w_own_oh;
            prog_rdy   = (r_owner == OWN_PROG);
            w_state_nx = ST_IDLE;
          end else begin
            w_state_nx = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        ba_dst = w_own_oh & {4{sdram_dst}};
        ba_dok = w_own_oh & {4{sdram_dok}};
        if (sdram_rdy) begin
          ba_rdy     = w_own_oh;
          prog_rdy   = (r_owner == OWN_PROG);
          w_state_nx = ST_IDLE;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // Command latches and arbitration history, captured only at grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner  <= OWN_B0;
      r_we     <= 1'b0;
      r_ba     <= '0;
      r_addr   <= '0;
      r_din    <= '0;
      r_mask   <= '0;
      r_rr_ptr <= '0;
      r_starve <= '0;
    end else if (w_load) begin
      r_owner  <= w_own_nx;
      r_we     <= w_ld_we;
      r_ba     <= w_ld_ba;
      r_addr   <= w_ld_addr;
      r_din    <= w_ld_din;
      r_mask   <= w_ld_mask;
      r_rr_ptr <= w_rr_nx;
      r_starve <= w_starve_nx;
    end
  end

  assign sdram_we   = r_we;
  assign sdram_ba   = r_ba;
  assign sdram_addr = r_addr;
  assign sdram_din  = r_din;
  assign sdram_mask = r_mask;

endmodule
